// File: rtl/sine_checksum_ctrl.sv
// Streams N_SAMPLES BRAM phase bytes into a CORDIC sine core, sums the sine results and checks
// the sum against EXPECTED_SUM. Define CHK_TIMEOUT_EN to add a watchdog on the DRAIN phase.
module sine_checksum_ctrl #(
  parameter int unsigned      ADDR_W       = 4,
  parameter int unsigned      DATA_W       = 8,
  parameter int unsigned      N_SAMPLES    = 10,
  parameter int unsigned      BRAM_LAT     = 1,
  parameter int unsigned      SUM_W        = 32,
  parameter logic [SUM_W-1:0] EXPECTED_SUM = '0,
  parameter int unsigned      TIMEOUT      = 64
) (
  input  logic              CLK100MHZ,
  input  logic              reset_in,
  input  logic              start,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              phase_tvalid,
  output logic [DATA_W-1:0] phase_tdata,
  input  logic              dout_tvalid,
  input  logic [31:0]       dout_sin,
  output logic              busy,
  output logic              done,
  output logic              success,
  output logic              error,
  output logic [SUM_W-1:0]  sum_out
);

  localparam int unsigned       CntW     = $clog2(N_SAMPLES + 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(N_SAMPLES - 1);
  localparam logic [CntW-1:0]   NCnt     = CntW'(N_SAMPLES);

  if (N_SAMPLES < 1 || N_SAMPLES > (1 << ADDR_W)) begin : g_bad_n_samples
    $error("N_SAMPLES must be in 1..2**ADDR_W");
  end
  if (BRAM_LAT < 1 || BRAM_LAT > 3) begin : g_bad_bram_lat
    $error("BRAM_LAT must be in 1..3");
  end
  if (SUM_W < 32 || TIMEOUT < 1) begin : g_bad_sum_timeout
    $error("SUM_W must be >= 32 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StCheck} state_e;

  state_e               state_q;
  logic                 bram_en_q;
  logic [ADDR_W-1:0]    bram_addr_q;
  logic [BRAM_LAT-1:0]  vld_sr_q, vld_sr_d;
  logic                 phase_tvalid_q;
  logic [DATA_W-1:0]    phase_tdata_q;
  logic [CntW-1:0]      res_cnt_q, res_cnt_d;
  logic [SUM_W-1:0]     acc_q, acc_d;
  logic                 busy_q, done_q, success_q, error_q, to_q;
  logic [SUM_W-1:0]     sum_out_q;
  logic                 res_take;
  logic signed [SUM_W-1:0] sin_ext;
  logic                 timed_out;

`ifdef CHK_TIMEOUT_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);
  logic [WdogW-1:0] wdog_q;

  // Counts cycles spent in DRAIN; restarts whenever DRAIN is entered.
  always_ff @(posedge CLK100MHZ) begin
    if (reset_in || state_q != StDrain) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + 1'b1;
    end
  end

  assign timed_out = (wdog_q == WdogW'(TIMEOUT - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    sin_ext   = SUM_W'($signed(dout_sin));
    res_take  = dout_tvalid && (state_q == StIssue || state_q == StDrain) && (res_cnt_q != NCnt);
    acc_d     = acc_q;
    res_cnt_d = res_cnt_q;
    if (res_take) begin
      acc_d     = acc_q + sin_ext;
      res_cnt_d = res_cnt_q + 1'b1;
    end
    // Bit i set means a read issued i+1 cycles ago; the top bit lines up with valid douta.
    vld_sr_d = (vld_sr_q << 1) | BRAM_LAT'(bram_en_q);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset_in) begin
      state_q        <= StIdle;
      bram_en_q      <= 1'b0;
      bram_addr_q    <= '0;
      vld_sr_q       <= '0;
      phase_tvalid_q <= 1'b0;
      phase_tdata_q  <= '0;
      res_cnt_q      <= '0;
      acc_q          <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      success_q      <= 1'b0;
      error_q        <= 1'b0;
      to_q           <= 1'b0;
      sum_out_q      <= '0;
    end else begin
      vld_sr_q       <= vld_sr_d;
      phase_tvalid_q <= vld_sr_q[BRAM_LAT-1];
      if (vld_sr_q[BRAM_LAT-1]) begin
        phase_tdata_q <= bram_dout;
      end
      acc_q     <= acc_d;
      res_cnt_q <= res_cnt_d;
      done_q    <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StIssue;
            busy_q      <= 1'b1;
            bram_en_q   <= 1'b1;
            bram_addr_q <= '0;
            acc_q       <= '0;
            res_cnt_q   <= '0;
            success_q   <= 1'b0;
            error_q     <= 1'b0;
            to_q        <= 1'b0;
          end
        end
        StIssue: begin
          if (bram_addr_q == LastAddr) begin
            state_q     <= StDrain;
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
          end else begin
            bram_addr_q <= bram_addr_q + 1'b1;
          end
        end
        StDrain: begin
          if (res_cnt_q == NCnt) begin
            state_q <= StCheck;
          end else if (timed_out) begin
            state_q <= StCheck;
            to_q    <= 1'b1;
          end
        end
        StCheck: begin
          state_q   <= StIdle;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          sum_out_q <= acc_q;
          if (!to_q && acc_q == EXPECTED_SUM) begin
            success_q <= 1'b1;
          end else begin
            error_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bram_en      = bram_en_q;
  assign bram_addr    = bram_addr_q;
  assign phase_tvalid = phase_tvalid_q;
  assign phase_tdata  = phase_tdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign success      = success_q;
  assign error        = error_q;
  assign sum_out      = sum_out_q;

endmodule
